program_loader: RTL and testbench

- Sequences the boot of the single-cycle RV32 core.
- Accepts the program as a byte stream (UART/JTAG-style valid/ready), packs bytes little-endian into 32-bit words and writes them to instruction memory at incrementing byte addresses 0, 4, 8, ...
- After the last word is written, performs the prog_ready/prog_ack handshake with the program counter, then holds the core in RUN.
- Sits between the external loader interface and the instruction_memory write port plus program_counter start inputs.

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/program_loader_byte_word_packer.sv | 63 ++++++
 rtl/program_loader.sv | 137 +++++++++++++
 tb/tb_program_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot program loader.
//   loader_state_t : loader FSM states
//   WORD_BYTES     : bytes per instruction word
//   PAD_BYTE       : fill value for lanes not supplied by the stream
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HANDOFF,
        RUN,
        ERROR
    } loader_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [7:0]  PAD_BYTE   = 8'h00;

endpackage

// File: rtl/program_loader_byte_word_packer.sv
// Packs an accepted byte stream little-endian into words.
// A completed word (lane 3 filled, or last byte seen) is moved into a
// separate write register so the next byte can be taken without a stall.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear          : restart packing (drops any partial word)
//   accept         : byte_data is taken this cycle
//   last           : accepted byte ends the program (flushes a partial word)
//   byte_data      : stream byte
//   word_valid     : one-cycle pulse, word holds a completed word
//   word           : completed word (unfilled lanes padded)
module program_loader_byte_word_packer
    import program_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic                  last,
    input  logic [7:0]            byte_data,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int unsigned LANES  = DATA_WIDTH / 8;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam logic [DATA_WIDTH-1:0] PAD_WORD  = {LANES{PAD_BYTE}};
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);

    logic [LANE_W-1:0]     lane;
    logic [DATA_WIDTH-1:0] assembler;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged = assembler;
        merged[8*int'(lane) +: 8] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane       <= '0;
            assembler  <= PAD_WORD;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (accept) begin
                if (lane == LAST_LANE || last) begin
                    word       <= merged;
                    word_valid <= 1'b1;
                    assembler  <= PAD_WORD;
                    lane       <= '0;
                end else begin
                    assembler  <= merged;
                    lane       <= lane + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot sequencer for the single-cycle RV32 core: receives the program as
// a byte stream, writes packed words to instruction memory from address 0,
// then hands off to the program counter via prog_ready/prog_ack.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   load_start                      : pulse that begins a (re)load
//   byte_valid/byte_data/byte_last  : byte stream in
//   byte_ready                      : loader takes a byte this cycle
//   imem_w_en/imem_wr_addr/imem_data_in : instruction memory write port
//   prog_ready, prog_ack            : PC start handshake
//   cpu_run                         : core released
//   load_err                        : overflow or ack timeout (sticky)
//   word_count                      : words written in the current load
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned ACK_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  imem_w_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_data_in,
    output logic                  prog_ready,
    input  logic                  prog_ack,
    output logic                  cpu_run,
    output logic                  load_err,
    output logic [ADDR_WIDTH-2:0] word_count
);

    localparam int unsigned CAPACITY = MEM_DEPTH / WORD_BYTES;
    localparam int unsigned TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] CAP_W    = ADDR_WIDTH'(CAPACITY);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    loader_state_t state, state_next;

    logic                  last_seen;
    logic                  restart;
    logic                  take;
    logic                  accept;
    logic                  overflow;
    logic                  word_valid;
    logic [ADDR_WIDTH-1:0] committed;
    logic [TMO_W-1:0]      ack_cnt;

    assign restart = load_start && (state != LOAD);
    assign take    = byte_valid && byte_ready;

    // A word still in the write register counts as occupying a slot, so a
    // byte arriving in the same cycle as the final in-capacity write is
    // already beyond capacity.
    assign committed = {1'b0, word_count} + ADDR_WIDTH'(word_valid);
    assign overflow  = take && (committed == CAP_W);
    assign accept    = take && !overflow;

    program_loader_byte_word_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (restart),
        .accept    (accept),
        .last      (byte_last),
        .byte_data (byte_data),
        .word_valid(word_valid),
        .word      (imem_data_in)
    );

    assign imem_w_en    = word_valid;
    assign imem_wr_addr = {word_count[ADDR_WIDTH-3:0], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        prog_ready = 1'b0;
        cpu_run    = 1'b0;
        load_err   = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) state_next = LOAD;
            end
            LOAD: begin
                byte_ready = !last_seen;
                if (overflow)                    state_next = ERROR;
                else if (last_seen && word_valid) state_next = HANDOFF;
            end
            HANDOFF: begin
                prog_ready = 1'b1;
                if (load_start)               state_next = LOAD;
                else if (prog_ack)            state_next = RUN;
                else if (ack_cnt == TMO_LAST) state_next = ERROR;
            end
            RUN: begin
                prog_ready = 1'b1;
                cpu_run    = 1'b1;
                if (load_start) state_next = LOAD;
            end
            ERROR: begin
                load_err = 1'b1;
                if (load_start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
            last_seen  <= 1'b0;
            ack_cnt    <= '0;
        end else begin
            if (restart) begin
                word_count <= '0;
                last_seen  <= 1'b0;
            end else begin
                if (word_valid)         word_count <= word_count + (ADDR_WIDTH-1)'(1);
                if (accept && byte_last) last_seen <= 1'b1;
            end
            ack_cnt <= (state == HANDOFF) ? ack_cnt + TMO_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed boot scenarios plus
// randomized byte streams compared against a packing model built from the
// stream contents (expected words, addresses and write cycles).
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, load_start, byte_valid, byte_last, prog_ack;
    logic [7:0]  byte_data;
    logic        byte_ready, imem_w_en, prog_ready, cpu_run, load_err;
    logic [9:0]  imem_wr_addr;
    logic [31:0] imem_data_in;
    logic [8:0]  word_count;

    int nvec = 0;
    int nmis = 0;
    int unsigned cyc = 0;

    logic [7:0]  bytes_q[$];
    int unsigned acc_q[$];
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int unsigned wc_q[$];

    program_loader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_DEPTH(1024), .ACK_TIMEOUT(256)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready), .imem_w_en(imem_w_en),
        .imem_wr_addr(imem_wr_addr), .imem_data_in(imem_data_in),
        .prog_ready(prog_ready), .prog_ack(prog_ack), .cpu_run(cpu_run),
        .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_w_en === 1'b1) begin
            wa_q.push_back(imem_wr_addr);
            wd_q.push_back(imem_data_in);
            wc_q.push_back(cyc);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic restart();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_q.delete();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        @(negedge clk);
        check("restart_byte_ready", byte_ready, 1);
        check("restart_prog_ready", prog_ready, 0);
        check("restart_cpu_run", cpu_run, 0);
        check("restart_load_err", load_err, 0);
        check("restart_word_count", word_count, 0);
        @(posedge clk); #1;
    endtask

    task automatic fill_random(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
    endtask

    // Presents bytes_q; records the cycle in which each byte is taken.
    task automatic stream(input int gap_pct, input bit mark_last);
        for (int i = 0; i < bytes_q.size(); i++) begin
            int waited = 0;
            while (int'($urandom_range(99)) < gap_pct) begin
                byte_valid = 1'b0;
                @(posedge clk); #1;
            end
            byte_valid = 1'b1;
            byte_data  = bytes_q[i];
            byte_last  = mark_last && (i == bytes_q.size() - 1);
            forever begin
                @(negedge clk);
                if (byte_ready === 1'b1) break;
                waited++;
                if (waited > 50) break;
            end
            if (waited > 50) begin
                check("byte_ready_timeout", 0, 1);
                byte_valid = 1'b0; byte_last = 1'b0;
                return;
            end
            acc_q.push_back(cyc);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Model: bytes beyond 1024 are discarded; word i holds bytes 4i..4i+3
    // little-endian, zero padded, written at 4i one cycle after its final byte.
    task automatic verify(input int n);
        int nb = (n < 1024) ? n : 1024;
        int nw = (nb + 3) / 4;
        int m;
        check("write_count", wa_q.size(), nw);
        m = (wa_q.size() < nw) ? wa_q.size() : nw;
        for (int i = 0; i < m; i++) begin
            logic [31:0] w = '0;
            int trig = (4*i + 3 < nb) ? 4*i + 3 : nb - 1;
            for (int b = 0; b < 4; b++)
                if (4*i + b < nb) w[8*b +: 8] = bytes_q[4*i + b];
            check($sformatf("write%0d_addr", i), wa_q[i], 32'(4*i));
            check($sformatf("write%0d_data", i), wd_q[i], w);
            check($sformatf("write%0d_cycle", i), wc_q[i], acc_q[trig] + 1);
        end
    endtask

    task automatic wait_handoff();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (prog_ready !== 1'b1 && n < 100);
        check("handoff_prog_ready", prog_ready, 1);
        check("handoff_cpu_run", cpu_run, 0);
    endtask

    task automatic ack_after(input int delay);
        repeat (delay) @(posedge clk);
        #1 prog_ack = 1'b1;
        @(posedge clk); #1;
        prog_ack = 1'b0;
        @(negedge clk);
        check("run_cpu_run", cpu_run, 1);
        check("run_prog_ready", prog_ready, 1);
        check("run_byte_ready", byte_ready, 0);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
        byte_data = '0; prog_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_byte_ready", byte_ready, 0);
        check("reset_w_en", imem_w_en, 0);
        check("reset_outputs", {prog_ready, cpu_run, load_err}, 0);
        check("reset_word_count", word_count, 0);
        @(posedge clk); #1;

        // Two-instruction program from IDLE.
        restart();
        bytes_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        stream(0, 1'b1);
        wait_handoff();
        verify(8);
        check("t1_word_count", word_count, 2);
        ack_after(3);
        repeat (4) @(negedge clk);
        check("run_hold_cpu_run", cpu_run, 1);
        check("run_hold_prog_ready", prog_ready, 1);
        @(posedge clk); #1;

        // Reload from RUN, partial last word, then ack timeout.
        restart();
        bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        stream(0, 1'b1);
        wait_handoff();
        verify(5);
        check("t2_word_count", word_count, 2);
        repeat (255) @(negedge clk);
        check("tmo_last_prog_ready", prog_ready, 1);
        check("tmo_last_load_err", load_err, 0);
        @(negedge clk);
        check("tmo_load_err", load_err, 1);
        check("tmo_prog_ready", prog_ready, 0);
        @(posedge clk); #1;

        // Reload from ERROR, then load_start and prog_ack together in HANDOFF.
        restart();
        fill_random(int'($urandom_range(1, 12)));
        stream(30, 1'b1);
        wait_handoff();
        verify(bytes_q.size());
        @(posedge clk); #1;
        wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_q.delete();
        load_start = 1'b1; prog_ack = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0; prog_ack = 1'b0;
        @(negedge clk);
        check("both_prog_ready", prog_ready, 0);
        check("both_cpu_run", cpu_run, 0);
        check("both_byte_ready", byte_ready, 1);
        @(posedge clk); #1;
        fill_random(int'($urandom_range(1, 20)));
        stream(30, 1'b1);
        wait_handoff();
        verify(bytes_q.size());
        ack_after(int'($urandom_range(0, 5)));
        @(posedge clk); #1;

        // Randomized loads, each restarted from RUN.
        for (int it = 0; it < 6; it++) begin
            int n = int'($urandom_range(1, 40));
            restart();
            fill_random(n);
            stream(int'($urandom_range(0, 50)), 1'b1);
            wait_handoff();
            verify(n);
            check("rnd_word_count", word_count, 32'((n + 3) / 4));
            ack_after(int'($urandom_range(0, 6)));
            @(posedge clk); #1;
        end

        // Overflow: 1025 contiguous bytes into a 256-word memory.
        restart();
        fill_random(1025);
        stream(0, 1'b1);
        @(negedge clk);
        verify(1025);
        if (wa_q.size() > 0) check("ovf_last_addr", wa_q[wa_q.size()-1], 32'h3FC);
        check("ovf_load_err", load_err, 1);
        check("ovf_prog_ready", prog_ready, 0);
        check("ovf_word_count", word_count, 256);
        check("ovf_byte_ready", byte_ready, 0);
        @(posedge clk); #1;

        // Reset after 6 bytes of a load aborts; reload starts at 0.
        restart();
        fill_random(6);
        stream(0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_w_en", imem_w_en, 0);
        check("abort_flags", {byte_ready, prog_ready, cpu_run, load_err}, 0);
        check("abort_word_count", word_count, 0);
        check("abort_addr_data", {22'd0, imem_wr_addr} | imem_data_in, 0);
        repeat (5) @(negedge clk);
        check("abort_no_more_writes", wa_q.size(), 1);
        @(posedge clk); #1;
        restart();
        fill_random(4);
        stream(20, 1'b1);
        wait_handoff();
        verify(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
